// File: rtl/flash_pkg.sv
// Shared types for the flash device responder: packet IDs, endpoints, FSM states and
// the registered response record.
package flash_pkg;

  typedef enum logic [3:0] {
    PidOut   = 4'b0001,
    PidIn    = 4'b1001,
    PidData0 = 4'b0011,
    PidAck   = 4'b0010,
    PidNak   = 4'b1010
  } pid_e;

  localparam logic [3:0] EpAddr = 4'd4;
  localparam logic [3:0] EpData = 4'd8;

  typedef enum logic [1:0] {
    StIdle,
    StWaitData,
    StSendRsp,
    StWaitHs
  } state_e;

  // Tags what the pending DATA0 in StWaitData will be used for.
  typedef enum logic {
    DkAddr,
    DkWr
  } data_kind_e;

  // pid is plain logic so the all-zero reset value is representable.
  typedef struct packed {
    logic [3:0]  pid;
    logic [63:0] data;
  } rsp_t;

endpackage

// File: rtl/flash_store.sv
// Flash word array with per-word valid bits; unwritten words read back as zero.
module flash_store #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [63:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [63:0]       rdata
);

  localparam int unsigned Words = 2 ** ADDR_W;

  logic [63:0]      mem_q [Words];
  logic [Words-1:0] valid_q;

  // Contents are deliberately not reset; the valid bits mask them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[waddr] <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (valid_q[raddr]) begin
      rdata = mem_q[raddr];
    end
  end

endmodule

// File: rtl/flash_device_responder.sv
// Device-side endpoint controller: decodes host OUT/IN/DATA0 traffic, owns the flash store
// and answers with ACK/NAK/DATA0 through a held response register.
module flash_device_responder
  import flash_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'd5,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        pkt_valid,
  input  logic [3:0]  pkt_pid,
  input  logic [6:0]  pkt_addr,
  input  logic [3:0]  pkt_endp,
  input  logic [63:0] pkt_data,
  input  logic        pkt_crc_ok,
  output logic        rsp_valid,
  output logic [3:0]  rsp_pid,
  output logic [63:0] rsp_data,
  input  logic        rsp_ready,
  output logic        busy
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [16:0] Words = 17'(1) << ADDR_W;

  state_e            state_q, state_d;
  data_kind_e        kind_q, kind_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_ok_q, addr_ok_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  rsp_t              rsp_q, rsp_d;

  logic              we;
  logic [63:0]       rd_data;
  logic              tok_match;
  logic              timed_out;

  flash_store #(
    .ADDR_W(ADDR_W)
  ) u_store (
    .clk  (clk),
    .rst_L(rst_L),
    .we   (we),
    .waddr(addr_q),
    .wdata(pkt_data),
    .raddr(addr_q),
    .rdata(rd_data)
  );

  assign tok_match = pkt_valid && (pkt_addr == DEV_ADDR);
  assign timed_out = (tmr_q == TW'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    addr_d    = addr_q;
    addr_ok_d = addr_ok_q;
    rsp_d     = rsp_q;
    tmr_d     = tmr_q + TW'(1);
    we        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Leaving IDLE always enters a timed state with a fresh count.
        tmr_d = '0;
        if (tok_match && pkt_pid == PidOut && pkt_endp == EpAddr) begin
          state_d = StWaitData;
          kind_d  = DkAddr;
        end else if (tok_match && pkt_pid == PidOut && pkt_endp == EpData) begin
          if (addr_ok_q) begin
            state_d = StWaitData;
            kind_d  = DkWr;
          end else begin
            state_d    = StSendRsp;
            rsp_d.pid  = PidNak;
            rsp_d.data = '0;
          end
        end else if (tok_match && pkt_pid == PidIn && pkt_endp == EpData) begin
          state_d = StSendRsp;
          if (addr_ok_q) begin
            rsp_d.pid  = PidData0;
            rsp_d.data = rd_data;
          end else begin
            rsp_d.pid  = PidNak;
            rsp_d.data = '0;
          end
        end
      end

      StWaitData: begin
        if (pkt_valid) begin
          if (pkt_pid == PidData0) begin
            state_d    = StSendRsp;
            rsp_d.data = '0;
            if (!pkt_crc_ok) begin
              rsp_d.pid = PidNak;
            end else if (kind_q == DkAddr) begin
              if ({1'b0, pkt_data[15:0]} < Words) begin
                addr_d    = pkt_data[ADDR_W-1:0];
                addr_ok_d = 1'b1;
                rsp_d.pid = PidAck;
              end else begin
                addr_ok_d = 1'b0;
                rsp_d.pid = PidNak;
              end
            end else begin
              we        = 1'b1;
              rsp_d.pid = PidAck;
            end
          end else begin
            state_d = StIdle;
          end
        end else if (timed_out) begin
          state_d = StIdle;
        end
      end

      StSendRsp: begin
        tmr_d = '0;
        if (rsp_ready) begin
          state_d = (rsp_q.pid == PidData0) ? StWaitHs : StIdle;
        end
      end

      StWaitHs: begin
        // Any host packet or a timeout ends the read; a retry simply re-reads the word.
        if (pkt_valid || timed_out) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q   <= StIdle;
      kind_q    <= DkAddr;
      addr_q    <= '0;
      addr_ok_q <= 1'b0;
      tmr_q     <= '0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      addr_q    <= addr_d;
      addr_ok_q <= addr_ok_d;
      tmr_q     <= tmr_d;
      rsp_q     <= rsp_d;
    end
  end

  assign rsp_valid = (state_q == StSendRsp);
  assign rsp_pid   = rsp_q.pid;
  assign rsp_data  = rsp_q.data;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_flash_device_responder.sv
// Bench for flash_device_responder: directed vector table, hand-written corner sequences
// and random transactions checked against a word-map model of the device.
module tb_flash_device_responder;
  import flash_pkg::*;

  localparam logic [6:0]  Dev     = 7'd5;
  localparam int unsigned AddrW   = 8;
  localparam int unsigned Timeout = 255;

  localparam int OpAddr = 0;
  localparam int OpWrite = 1;
  localparam int OpWtok = 2;
  localparam int OpRead = 3;

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic        pkt_valid = 1'b0;
  logic [3:0]  pkt_pid = '0;
  logic [6:0]  pkt_addr = '0;
  logic [3:0]  pkt_endp = '0;
  logic [63:0] pkt_data = '0;
  logic        pkt_crc_ok = 1'b1;
  logic        rsp_valid;
  logic [3:0]  rsp_pid;
  logic [63:0] rsp_data;
  logic        rsp_ready = 1'b1;
  logic        busy;

  int n_tests = 0;
  int n_fail = 0;

  flash_device_responder #(
    .DEV_ADDR(Dev),
    .ADDR_W  (AddrW),
    .TIMEOUT (Timeout)
  ) dut (
    .clk       (clk),
    .rst_L     (rst_L),
    .pkt_valid (pkt_valid),
    .pkt_pid   (pkt_pid),
    .pkt_addr  (pkt_addr),
    .pkt_endp  (pkt_endp),
    .pkt_data  (pkt_data),
    .pkt_crc_ok(pkt_crc_ok),
    .rsp_valid (rsp_valid),
    .rsp_pid   (rsp_pid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One-cycle packet strobe, driven on a falling edge.
  task automatic send_pkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                          input logic [63:0] data, input logic crc);
    @(negedge clk);
    pkt_pid    = pid;
    pkt_addr   = addr;
    pkt_endp   = endp;
    pkt_data   = data;
    pkt_crc_ok = crc;
    pkt_valid  = 1'b1;
    @(negedge clk);
    pkt_valid  = 1'b0;
  endtask

  task automatic get_rsp(output logic ok, output logic [3:0] pid, output logic [63:0] data,
                         output int lat);
    ok   = 1'b0;
    pid  = '0;
    data = '0;
    lat  = -1;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        ok   = 1'b1;
        pid  = rsp_pid;
        data = rsp_data;
        lat  = i;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
  endtask

  task automatic do_op(input int op, input logic [63:0] val, input logic crc, input logic host_ack,
                       output logic ok, output logic [3:0] pid, output logic [63:0] data,
                       output int lat);
    case (op)
      OpAddr: begin
        send_pkt(PidOut, Dev, EpAddr, '0, 1'b1);
        send_pkt(PidData0, Dev, 4'd0, val, crc);
      end
      OpWrite: begin
        send_pkt(PidOut, Dev, EpData, '0, 1'b1);
        send_pkt(PidData0, Dev, 4'd0, val, crc);
      end
      OpWtok: send_pkt(PidOut, Dev, EpData, '0, 1'b1);
      default: send_pkt(PidIn, Dev, EpData, '0, 1'b1);
    endcase
    get_rsp(ok, pid, data, lat);
    if (host_ack && ok && pid == PidData0) send_pkt(PidAck, Dev, 4'd0, '0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_L = 1'b0;
    @(negedge clk);
    rst_L = 1'b1;
  endtask

  typedef struct {
    int          op;
    logic [63:0] val;
    logic        crc;
    logic [3:0]  exp_pid;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  // Reference model: sparse word map plus the host-visible address state.
  logic [63:0] m_mem[int];
  logic        m_ok;
  int          m_addr;

  initial begin
    logic        ok;
    logic [3:0]  pid;
    logic [63:0] data;
    int          lat;
    int          cnt;
    int          bad;
    logic [3:0]  cap_pid;
    logic [63:0] cap_data;

    vecs.push_back('{OpAddr, 64'h00AB, 1'b1, PidAck, 64'h0});
    vecs.push_back('{OpWrite, 64'hCAFEBABEDEADBEEF, 1'b1, PidAck, 64'h0});
    vecs.push_back('{OpAddr, 64'h00AB, 1'b1, PidAck, 64'h0});
    vecs.push_back('{OpRead, 64'h0, 1'b1, PidData0, 64'hCAFEBABEDEADBEEF});
    vecs.push_back('{OpAddr, 64'h00AC, 1'b1, PidAck, 64'h0});
    vecs.push_back('{OpRead, 64'h0, 1'b1, PidData0, 64'h0});
    vecs.push_back('{OpAddr, 64'h0100, 1'b1, PidNak, 64'h0});
    vecs.push_back('{OpRead, 64'h0, 1'b1, PidNak, 64'h0});
    vecs.push_back('{OpWtok, 64'h0, 1'b1, PidNak, 64'h0});
    vecs.push_back('{OpAddr, 64'h00AB, 1'b1, PidAck, 64'h0});
    vecs.push_back('{OpWrite, 64'h1111, 1'b0, PidNak, 64'h0});
    vecs.push_back('{OpRead, 64'h0, 1'b1, PidData0, 64'hCAFEBABEDEADBEEF});
    vecs.push_back('{OpAddr, 64'h00AC, 1'b0, PidNak, 64'h0});
    vecs.push_back('{OpRead, 64'h0, 1'b1, PidData0, 64'hCAFEBABEDEADBEEF});
    vecs.push_back('{OpAddr, 64'hFFFFFFFFFFFF00FF, 1'b1, PidAck, 64'h0});
    vecs.push_back('{OpWrite, 64'h0123456789ABCDEF, 1'b1, PidAck, 64'h0});
    vecs.push_back('{OpRead, 64'h0, 1'b1, PidData0, 64'h0123456789ABCDEF});
    vecs.push_back('{OpAddr, 64'hFFFF, 1'b1, PidNak, 64'h0});
    vecs.push_back('{OpAddr, 64'h0000, 1'b1, PidAck, 64'h0});
    vecs.push_back('{OpWrite, 64'h5A, 1'b1, PidAck, 64'h0});
    vecs.push_back('{OpRead, 64'h0, 1'b1, PidData0, 64'h5A});

    // Reset state
    #2;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_pid", 64'(rsp_pid), 64'd0);
    check("reset_rsp_data", rsp_data, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_L = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].val, vecs[i].crc, 1'b1, ok, pid, data, lat);
      check($sformatf("vec%0d_seen", i), 64'(ok), 64'd1);
      check($sformatf("vec%0d_pid", i), 64'(pid), 64'(vecs[i].exp_pid));
      if (vecs[i].exp_pid == PidData0) check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd0);
      check($sformatf("vec%0d_idle", i), 64'(busy), 64'd0);
    end

    // Handshake timeout, then retry returns the same word
    do_op(OpAddr, 64'h00AB, 1'b1, 1'b1, ok, pid, data, lat);
    check("to_addr_pid", 64'(pid), 64'(PidAck));
    do_op(OpRead, 64'h0, 1'b1, 1'b0, ok, pid, data, lat);
    check("to_read_data", data, 64'hCAFEBABEDEADBEEF);
    check("to_busy_waiting", 64'(busy), 64'd1);
    cnt = 0;
    while (busy && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check("to_busy_fell", 64'(busy), 64'd0);
    check("to_wait_in_window", 64'(cnt >= int'(Timeout) && cnt <= int'(Timeout) + 2), 64'd1);
    do_op(OpRead, 64'h0, 1'b1, 1'b1, ok, pid, data, lat);
    check("to_retry_pid", 64'(pid), 64'(PidData0));
    check("to_retry_data", data, 64'hCAFEBABEDEADBEEF);

    // Backpressure: response held stable while rsp_ready is low
    rsp_ready = 1'b0;
    send_pkt(PidIn, Dev, EpData, '0, 1'b1);
    cap_pid  = rsp_pid;
    cap_data = rsp_data;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || rsp_pid !== cap_pid || rsp_data !== cap_data) bad++;
      @(negedge clk);
    end
    check("bp_stable_cycles_bad", 64'(bad), 64'd0);
    check("bp_pid", 64'(cap_pid), 64'(PidData0));
    check("bp_data", cap_data, 64'hCAFEBABEDEADBEEF);
    rsp_ready = 1'b1;
    get_rsp(ok, pid, data, lat);
    check("bp_released", 64'(ok), 64'd1);
    send_pkt(PidAck, Dev, 4'd0, '0, 1'b1);
    check("bp_idle", 64'(busy), 64'd0);

    // Address and endpoint filtering
    bad = 0;
    send_pkt(PidOut, 7'd3, EpAddr, '0, 1'b1);
    if (busy) bad++;
    send_pkt(PidData0, 7'd3, 4'd0, 64'h0010, 1'b1);
    if (busy || rsp_valid) bad++;
    send_pkt(PidIn, 7'd3, EpData, '0, 1'b1);
    if (busy || rsp_valid) bad++;
    send_pkt(PidOut, Dev, 4'd2, '0, 1'b1);
    if (busy || rsp_valid) bad++;
    repeat (3) begin
      @(negedge clk);
      if (busy || rsp_valid) bad++;
    end
    check("filter_no_activity", 64'(bad), 64'd0);

    // Reset between write token and its DATA0
    do_op(OpAddr, 64'h0040, 1'b1, 1'b1, ok, pid, data, lat);
    check("rst_addr_pid", 64'(pid), 64'(PidAck));
    send_pkt(PidOut, Dev, EpData, '0, 1'b1);
    check("rst_busy_before", 64'(busy), 64'd1);
    rst_L = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_L = 1'b1;
    do_op(OpRead, 64'h0, 1'b1, 1'b1, ok, pid, data, lat);
    check("rst_read_no_addr_pid", 64'(pid), 64'(PidNak));
    do_op(OpAddr, 64'h0040, 1'b1, 1'b1, ok, pid, data, lat);
    do_op(OpRead, 64'h0, 1'b1, 1'b1, ok, pid, data, lat);
    check("rst_read_pid", 64'(pid), 64'(PidData0));
    check("rst_read_data", data, 64'd0);

    // Random transactions against the model
    do_reset();
    m_mem.delete();
    m_ok = 1'b0;
    m_addr = 0;
    for (int t = 0; t < 200; t++) begin
      int          op;
      logic [63:0] val;
      logic        crc;
      logic [3:0]  e_pid;
      logic [63:0] e_data;
      op  = int'($urandom_range(0, 2));
      crc = ($urandom_range(0, 9) != 0);
      val = {$urandom(), $urandom()};
      e_data = '0;
      if (op == 0) begin
        if ($urandom_range(0, 7) == 0) val[15:0] = 16'(256 + $urandom_range(0, 1000));
        else val[15:0] = 16'($urandom_range(0, 9));
        if (!crc) e_pid = PidNak;
        else if (int'(val[15:0]) < 256) begin
          e_pid = PidAck;
          m_ok = 1'b1;
          m_addr = int'(val[15:0]);
        end else begin
          e_pid = PidNak;
          m_ok = 1'b0;
        end
        op = OpAddr;
      end else if (op == 1) begin
        if (!m_ok) begin
          op = OpWtok;
          e_pid = PidNak;
        end else begin
          op = OpWrite;
          e_pid = crc ? PidAck : PidNak;
          if (crc) m_mem[m_addr] = val;
        end
      end else begin
        op = OpRead;
        if (!m_ok) e_pid = PidNak;
        else begin
          e_pid = PidData0;
          e_data = m_mem.exists(m_addr) ? m_mem[m_addr] : 64'd0;
        end
      end
      do_op(op, val, crc, 1'b1, ok, pid, data, lat);
      check($sformatf("rnd%0d_pid", t), 64'(pid), 64'(e_pid));
      if (e_pid == PidData0) check($sformatf("rnd%0d_data", t), data, e_data);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
